seg_beat_packer: RTL and testbench
==================================

Name: seg_beat_packer

Overview:
- Synthesizable packer that converts a narrow packet stream (sop/eop/dval/mod/data, one segment per cycle) into a segmented wide bus of SEG_NUM segments per beat.
- Each segment carries its own sop/eop/dval, a packet ordinal and a zero-byte count.
- Successor to the testbench-only segment converter, adding:
  - parametrised width and segment count;
  - a valid/ready handshake on both sides;
  - a double-buffered output;
  - idle-timeout flush of partial beats;
  - protocol error detection.
- Sits between the 64-bit packet sources and the segmented CRC engine.

Parameters:
- SEG_BYTES, 8: bytes per segment, equal to the input word width / 8; power of 2.
- SEG_NUM, 64: segments per output beat; power of 2, at least 2.
- MOD_W, 3: log2(SEG_BYTES); width of in_mod.
- PKTN_W, 4: width of the per-segment packet ordinal.
- ZERO_W, 12: width of the per-segment zero-byte count; must hold SEG_NUM*SEG_BYTES-1.
- FLUSH_CYCLES, 16: idle cycles before a partial beat is emitted; 0 disables flush.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- in_sop  in  1  first word of a packet.
- in_eop  in  1  last word of a packet.
- in_dval  in  1  input word valid.
- in_mod  in  MOD_W  valid bytes in the eop word; 0 means all SEG_BYTES are valid.
- in_data  in  SEG_BYTES*8  input word, first byte in the MSBs.
- in_ready  out  1  packer can accept a word this cycle.
- out_valid  out  1  beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_seg_sop  out  SEG_NUM  per-segment sop.
- out_seg_eop  out  SEG_NUM  per-segment eop.
- out_seg_dval  out  SEG_NUM  per-segment data valid.
- out_seg_pkt_num  out  SEG_NUM*PKTN_W  per-segment packet ordinal within the beat.
- out_seg_zero_num  out  SEG_NUM*ZERO_W  bytes from the eop end to the beat end; 0 for non-eop segments.
- out_seg_data  out  SEG_NUM*SEG_BYTES*8  segment data.
- err_proto  out  1  sticky protocol error.
- err_pkt_ovf  out  1  sticky packet-ordinal saturation.

Behaviour:
- Reset:
  - All outputs are 0; in_ready is 0 while rst is high.
  - Write pointer = SEG_NUM-1, pkt_idx = 1, state = IDLE, idle counter = 0, assembly buffer cleared.
  - Reset mid-beat discards the partial beat and the held beat with no output.
- Accept rule: a word is accepted when in_dval and in_ready are both high. Words presented with in_dval=0 consume no segment.
- Segment placement:
  - The first word of a beat goes to segment SEG_NUM-1 (MSB end); the pointer counts down to 0.
  - Segment i occupies data bits [i*SEG_BYTES*8 +: SEG_BYTES*8].
- Stamping of the written segment p:
  - sop, eop and dval are copied from the input; dval is 1.
  - pkt_num = pkt_idx.
  - zero_num = p*SEG_BYTES + (in_mod==0 ? 0 : SEG_BYTES-in_mod) when eop, else 0.
- pkt_idx rules:
  - Restarts at 1 for every beat.
  - Increments after each accepted eop within the beat.
  - Saturates at 2^PKTN_W-1; an eop that would exceed it sets err_pkt_ovf.
- Packet FSM:
  - IDLE to IN_PKT on accepted sop without eop.
  - IN_PKT to IDLE on accepted eop.
  - sop+eop in the same word stays in IDLE.
  - The following set err_proto; the word is still packed and the state follows the flags:
    - sop accepted in IN_PKT;
    - eop accepted in IDLE without sop;
    - non-sop word accepted in IDLE.
- Beat completion is either of:
  - the word written to segment 0 is accepted;
  - flush: idle counter == FLUSH_CYCLES with the pointer != SEG_NUM-1.
- Idle counter:
  - Counts cycles with a partial beat and no accepted word.
  - Resets on any accept.
  - An accept in the flush cycle wins: the flush is suppressed.
- Flush output: unwritten segments are emitted with dval/sop/eop = 0, pkt_num = 0, zero_num = 0 and data 0. A packet may span a flushed beat and continue in the next one.
- Transfer:
  - On completion, if the hold register is free (out_valid==0 or out_ready==1), the beat moves to the hold register at that edge.
  - out_valid rises the next cycle, giving 1-cycle latency from the last accept.
  - Otherwise asm_full is set and in_ready=0. The transfer happens at the first edge where the hold register is free; in_ready returns to 1 the cycle after.
- in_ready = !rst && !asm_full.
- Output hold:
  - out_* stay stable while out_valid && !out_ready.
  - out_valid falls after a handshake unless a new beat transfers at the same edge (back-to-back beats are allowed, no bubble).
- The buffer is reset to the empty state (pointer = SEG_NUM-1, pkt_idx = 1, stamps cleared) at each transfer.

Optional Feature:
- SEG_BEAT_PACKER_BIT_REVERSE_EN defined: in_data is bit-reversed within each byte before packing (bit 7 swaps with bit 0 in every byte). Combinational on the write path, so latency is unchanged.
- Undefined: data is packed unmodified.

Decomposition:
- Package seg_beat_packer_pkg holds:
  - defaults for SEG_BYTES and SEG_NUM;
  - a clog2 function;
  - the zero_num calculation function;
  - the packet FSM state enum (IDLE, IN_PKT).
- Sub-module seg_beat_hold: the output hold register with valid/ready and a free indication. Instantiated once.

Test Plan:
- SEG_NUM=4, four-word packet sop..eop, mod=0, out_ready=1 -> one beat:
  - seg_sop=4'b1000, seg_eop=4'b0001, seg_dval=4'b1111;
  - all pkt_num=1, seg0 zero_num=0;
  - out_valid rises 1 cycle after the 4th accept.
- SEG_NUM=4, a 1-word packet (sop+eop, mod=3) then a 3-word packet, mod=0 -> seg3:
  - eop=1, zero_num=3*8+5=29, pkt_num=1;
  - seg2..0 pkt_num=2, seg0 zero_num=0.
- Two words, then in_dval=0 for 16 cycles, FLUSH_CYCLES=16 -> beat with seg_dval=4'b1100, seg1/seg0 fully zeroed; err_proto stays 0 if the packet is still open.
- out_ready=0 for 10 cycles while streaming 12 words:
  - the second beat completes;
  - in_ready=0 until out_ready rises;
  - no word is lost or duplicated;
  - beats are emitted in order.
- Protocol errors: sop, then sop again without an eop -> err_proto=1 and it stays sticky; rst=1 for one cycle mid-beat -> all outputs 0 and the partial beat is discarded.
- Default parameters, 9 one-word packets within one beat with PKTN_W=3 -> pkt_num saturates at 7 and err_pkt_ovf=1.

Source files
------------

// File: rtl/seg_beat_packer_pkg.sv
// rtl/seg_beat_packer_pkg.sv - shared defaults, helpers and packet FSM state for seg_beat_packer
package seg_beat_packer_pkg;

  localparam int SEG_BYTES_DEF = 8;
  localparam int SEG_NUM_DEF   = 64;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } pkt_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Bytes from the eop byte to the MSB-first end of the beat (segment 0 is last).
  function automatic int calc_zero_num(input int seg, input int mod, input int seg_bytes);
    return seg * seg_bytes + ((mod == 0) ? 0 : (seg_bytes - mod));
  endfunction

endpackage

// File: rtl/seg_beat_packer_if.sv
// rtl/seg_beat_packer_if.sv - narrow input stream and segmented output beat bundle
interface seg_beat_packer_if #(
  parameter int SEG_BYTES = 8,
  parameter int SEG_NUM   = 64,
  parameter int MOD_W     = 3,
  parameter int PKTN_W    = 4,
  parameter int ZERO_W    = 12
) ();

  logic                            in_sop;
  logic                            in_eop;
  logic                            in_dval;
  logic [MOD_W-1:0]                in_mod;
  logic [SEG_BYTES*8-1:0]          in_data;
  logic                            in_ready;
  logic                            out_valid;
  logic                            out_ready;
  logic [SEG_NUM-1:0]              out_seg_sop;
  logic [SEG_NUM-1:0]              out_seg_eop;
  logic [SEG_NUM-1:0]              out_seg_dval;
  logic [SEG_NUM*PKTN_W-1:0]       out_seg_pkt_num;
  logic [SEG_NUM*ZERO_W-1:0]       out_seg_zero_num;
  logic [SEG_NUM*SEG_BYTES*8-1:0]  out_seg_data;

  modport master (
    output in_sop, in_eop, in_dval, in_mod, in_data, out_ready,
    input  in_ready, out_valid, out_seg_sop, out_seg_eop, out_seg_dval,
           out_seg_pkt_num, out_seg_zero_num, out_seg_data
  );

  modport slave (
    input  in_sop, in_eop, in_dval, in_mod, in_data, out_ready,
    output in_ready, out_valid, out_seg_sop, out_seg_eop, out_seg_dval,
           out_seg_pkt_num, out_seg_zero_num, out_seg_data
  );

endinterface

// File: rtl/seg_beat_hold.sv
// rtl/seg_beat_hold.sv - output hold register for one assembled beat with valid/ready
module seg_beat_hold #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         out_ready_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic         free_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q;

  // Free in the same cycle the held beat is being taken, so beats go back-to-back.
  assign free_o  = !valid_q || out_ready_i;
  assign valid_d = load_i || (valid_q && !out_ready_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      if (load_i) data_q <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/seg_beat_packer.sv
// rtl/seg_beat_packer.sv - packs a narrow packet stream into segmented wide beats
// SEG_BEAT_PACKER_BIT_REVERSE_EN: bit-reverse each input byte on the write path.
module seg_beat_packer
  import seg_beat_packer_pkg::*;
#(
  parameter int SEG_BYTES    = SEG_BYTES_DEF,
  parameter int SEG_NUM      = SEG_NUM_DEF,
  parameter int MOD_W        = 3,
  parameter int PKTN_W       = 4,
  parameter int ZERO_W       = 12,
  parameter int FLUSH_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  seg_beat_packer_if.slave  bus,
  output logic              err_proto,
  output logic              err_pkt_ovf
);

  localparam int DW     = SEG_BYTES * 8;
  localparam int SEG_W  = clog2(SEG_NUM);
  localparam int HOLD_W = SEG_NUM * (3 + PKTN_W + ZERO_W + DW);
  localparam int IDLE_W = clog2(FLUSH_CYCLES + 1) + 1;
  localparam logic [SEG_W-1:0]  PTR_TOP   = SEG_W'(SEG_NUM - 1);
  localparam logic [PKTN_W-1:0] PKT_MAX   = {PKTN_W{1'b1}};
  localparam logic [IDLE_W-1:0] FLUSH_LIM = IDLE_W'(FLUSH_CYCLES);

  pkt_state_e                state_q, state_d;
  logic [SEG_W-1:0]          wptr_q, wptr_d;
  logic [PKTN_W-1:0]         pkt_idx_q, pkt_idx_d;
  logic [IDLE_W-1:0]         idle_q, idle_d;
  logic                      asm_full_q, asm_full_d;
  logic                      err_proto_q, err_ovf_q, err_ovf_d;
  logic                      proto_hit;

  logic [SEG_NUM-1:0]        sop_q, eop_q, dval_q;
  logic [SEG_NUM*PKTN_W-1:0] pkt_q;
  logic [SEG_NUM*ZERO_W-1:0] zero_q;
  logic [SEG_NUM*DW-1:0]     data_q;

  logic [SEG_NUM-1:0]        sop_w, eop_w, dval_w;
  logic [SEG_NUM*PKTN_W-1:0] pkt_w;
  logic [SEG_NUM*ZERO_W-1:0] zero_w;
  logic [SEG_NUM*DW-1:0]     data_w;

  logic [DW-1:0]             wdata;
  logic                      in_ready, accept, partial, flush, complete, transfer;
  logic                      hold_free;
  logic [HOLD_W-1:0]         hold_data;

`ifdef SEG_BEAT_PACKER_BIT_REVERSE_EN
  always_comb begin
    wdata = '0;
    for (int b = 0; b < DW; b++) begin
      wdata[b] = bus.in_data[(b / 8) * 8 + 7 - (b % 8)];
    end
  end
`else
  assign wdata = bus.in_data;
`endif

  assign in_ready     = !rst && !asm_full_q;
  assign bus.in_ready = in_ready;
  assign accept       = bus.in_dval && in_ready;
  assign partial      = (wptr_q != PTR_TOP) && !asm_full_q;
  // An accept in the would-be flush cycle restarts the idle count instead.
  assign flush        = (FLUSH_CYCLES != 0) && partial && !accept && (idle_q == FLUSH_LIM);
  assign complete     = (accept && (wptr_q == '0)) || flush;
  assign transfer     = hold_free && (complete || asm_full_q);

  // Buffer contents including this cycle's write; what the hold register loads.
  always_comb begin
    sop_w  = sop_q;
    eop_w  = eop_q;
    dval_w = dval_q;
    pkt_w  = pkt_q;
    zero_w = zero_q;
    data_w = data_q;
    if (accept) begin
      sop_w[wptr_q]                  = bus.in_sop;
      eop_w[wptr_q]                  = bus.in_eop;
      dval_w[wptr_q]                 = 1'b1;
      pkt_w[wptr_q*PKTN_W +: PKTN_W] = pkt_idx_q;
      zero_w[wptr_q*ZERO_W +: ZERO_W] = bus.in_eop
          ? ZERO_W'(calc_zero_num(int'(wptr_q), int'(bus.in_mod), SEG_BYTES)) : '0;
      data_w[wptr_q*DW +: DW]        = wdata;
    end
  end

  always_comb begin
    wptr_d     = wptr_q;
    pkt_idx_d  = pkt_idx_q;
    asm_full_d = asm_full_q;
    idle_d     = idle_q;
    err_ovf_d  = err_ovf_q;
    if (accept) begin
      wptr_d = wptr_q - 1'b1;
      if (bus.in_eop) begin
        if (pkt_idx_q == PKT_MAX) err_ovf_d = 1'b1;
        else                      pkt_idx_d = pkt_idx_q + 1'b1;
      end
    end
    if (transfer) begin
      wptr_d     = PTR_TOP;
      pkt_idx_d  = PKTN_W'(1);
      asm_full_d = 1'b0;
    end else if (complete) begin
      asm_full_d = 1'b1;
    end
    if (accept || !partial || complete) idle_d = '0;
    else if (idle_q != FLUSH_LIM)       idle_d = idle_q + 1'b1;
  end

  // Packet FSM: the next state follows the flags even when the word is a protocol error.
  always_comb begin
    state_d   = state_q;
    proto_hit = 1'b0;
    if (accept) begin
      if ((state_q == IN_PKT) && bus.in_sop)  proto_hit = 1'b1;
      if ((state_q == IDLE)   && !bus.in_sop) proto_hit = 1'b1;
      if (bus.in_eop)      state_d = IDLE;
      else if (bus.in_sop) state_d = IN_PKT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wptr_q      <= PTR_TOP;
      pkt_idx_q   <= PKTN_W'(1);
      idle_q      <= '0;
      asm_full_q  <= 1'b0;
      err_proto_q <= 1'b0;
      err_ovf_q   <= 1'b0;
      sop_q       <= '0;
      eop_q       <= '0;
      dval_q      <= '0;
      pkt_q       <= '0;
      zero_q      <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      pkt_idx_q   <= pkt_idx_d;
      idle_q      <= idle_d;
      asm_full_q  <= asm_full_d;
      err_proto_q <= err_proto_q || proto_hit;
      err_ovf_q   <= err_ovf_d;
      sop_q       <= transfer ? '0 : sop_w;
      eop_q       <= transfer ? '0 : eop_w;
      dval_q      <= transfer ? '0 : dval_w;
      pkt_q       <= transfer ? '0 : pkt_w;
      zero_q      <= transfer ? '0 : zero_w;
      data_q      <= transfer ? '0 : data_w;
    end
  end

  seg_beat_hold #(
    .W (HOLD_W)
  ) u_hold (
    .clk         (clk),
    .rst         (rst),
    .load_i      (transfer),
    .data_i      ({sop_w, eop_w, dval_w, pkt_w, zero_w, data_w}),
    .out_ready_i (bus.out_ready),
    .valid_o     (bus.out_valid),
    .data_o      (hold_data),
    .free_o      (hold_free)
  );

  assign {bus.out_seg_sop, bus.out_seg_eop, bus.out_seg_dval,
          bus.out_seg_pkt_num, bus.out_seg_zero_num, bus.out_seg_data} = hold_data;

  assign err_proto   = err_proto_q;
  assign err_pkt_ovf = err_ovf_q;

endmodule

// File: tb/tb_seg_beat_packer.sv
// tb/tb_seg_beat_packer.sv - scoreboard bench for seg_beat_packer (4-segment and 16-segment builds)
module tb_seg_beat_packer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err_a, ovf_a, err_b, ovf_b;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]   sop;
    logic [3:0]   eop;
    logic [3:0]   dval;
    logic [15:0]  pkt;
    logic [47:0]  zero;
    logic [255:0] data;
  } beat_t;

  beat_t exp_q[$];
  beat_t m_beat, last_beat;
  int    m_ptr, m_pkt;
  bit    stall_seen;

  seg_beat_packer_if #(.SEG_BYTES(8), .SEG_NUM(4), .MOD_W(3), .PKTN_W(4), .ZERO_W(12)) bus ();
  seg_beat_packer_if #(.SEG_BYTES(8), .SEG_NUM(16), .MOD_W(3), .PKTN_W(3), .ZERO_W(12)) busb ();

  seg_beat_packer #(
    .SEG_BYTES(8), .SEG_NUM(4), .MOD_W(3), .PKTN_W(4), .ZERO_W(12), .FLUSH_CYCLES(16)
  ) dut_a (
    .clk(clk), .rst(rst), .bus(bus), .err_proto(err_a), .err_pkt_ovf(ovf_a)
  );

  seg_beat_packer #(
    .SEG_BYTES(8), .SEG_NUM(16), .MOD_W(3), .PKTN_W(3), .ZERO_W(12), .FLUSH_CYCLES(0)
  ) dut_b (
    .clk(clk), .rst(rst), .bus(busb), .err_proto(err_b), .err_pkt_ovf(ovf_b)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [63:0] wr_data(input logic [63:0] d);
    logic [63:0] r;
    r = d;
`ifdef SEG_BEAT_PACKER_BIT_REVERSE_EN
    for (int b = 0; b < 64; b++) r[b] = d[(b / 8) * 8 + 7 - (b % 8)];
`endif
    return r;
  endfunction

  task automatic model_clear();
    m_beat = '0;
    m_ptr  = 3;
    m_pkt  = 1;
  endtask

  task automatic model_flush();
    exp_q.push_back(m_beat);
    model_clear();
  endtask

  task automatic model_accept(input logic s, input logic e, input logic [2:0] mod, input logic [63:0] d);
    m_beat.sop[m_ptr]  = s;
    m_beat.eop[m_ptr]  = e;
    m_beat.dval[m_ptr] = 1'b1;
    m_beat.pkt[m_ptr*4 +: 4]   = 4'(m_pkt);
    m_beat.zero[m_ptr*12 +: 12] = e ? 12'(m_ptr * 8 + ((mod == 0) ? 0 : 8 - int'(mod))) : 12'd0;
    m_beat.data[m_ptr*64 +: 64] = wr_data(d);
    if (e && m_pkt < 15) m_pkt++;
    if (m_ptr == 0) model_flush();
    else            m_ptr--;
  endtask

  task automatic drive_word(input logic s, input logic e, input logic [2:0] mod, input logic [63:0] d);
    int w;
    w = 0;
    @(negedge clk);
    bus.in_sop  = s;
    bus.in_eop  = e;
    bus.in_mod  = mod;
    bus.in_data = d;
    bus.in_dval = 1'b1;
    while (!bus.in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) check("in_ready_timeout", bus.in_ready, 1);
    @(posedge clk);
    if (w < 50) model_accept(s, e, mod, d);
    #1 bus.in_dval = 1'b0;
  endtask

  task automatic drive_b(input logic [63:0] d);
    @(negedge clk);
    busb.in_sop  = 1'b1;
    busb.in_eop  = 1'b1;
    busb.in_mod  = 3'd0;
    busb.in_data = d;
    busb.in_dval = 1'b1;
    if (!busb.in_ready) check("b_in_ready", busb.in_ready, 1);
    @(posedge clk);
    #1 busb.in_dval = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 60) begin
      @(negedge clk);
      w++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 0);
  endtask

  always @(negedge clk) begin
    beat_t got, e;
    if (!rst) begin
      if (!bus.out_ready && !bus.in_ready) stall_seen = 1'b1;
      if (bus.out_valid && bus.out_ready) begin
        got = {bus.out_seg_sop, bus.out_seg_eop, bus.out_seg_dval,
               bus.out_seg_pkt_num, bus.out_seg_zero_num, bus.out_seg_data};
        if (exp_q.size() == 0) begin
          check("beat_unexpected", 32'(exp_q.size()), 1);
        end else begin
          e = exp_q.pop_front();
          check("beat_sop",  got.sop,  e.sop);
          check("beat_eop",  got.eop,  e.eop);
          check("beat_dval", got.dval, e.dval);
          check("beat_pkt",  got.pkt,  e.pkt);
          check("beat_zero", got.zero, e.zero);
          check("beat_data", got.data, e.data);
        end
        last_beat = got;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          early;
    logic [47:0]  exp_pkt_b;
    logic [191:0] exp_zero_b;
    int           w;

    bus.in_sop = 0;  bus.in_eop = 0;  bus.in_dval = 0;  bus.in_mod = 0;  bus.in_data = 0;
    bus.out_ready = 1;
    busb.in_sop = 0; busb.in_eop = 0; busb.in_dval = 0; busb.in_mod = 0; busb.in_data = 0;
    busb.out_ready = 1;
    stall_seen = 0;
    last_beat  = '0;
    model_clear();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready",  bus.in_ready,  0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_seg_sop",   bus.out_seg_sop, 0);
    check("rst_seg_data",  bus.out_seg_data, 0);
    check("rst_err",       {err_a, ovf_a}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", bus.in_ready, 1);

    // Four-word packet and one-cycle latency
    drive_word(1, 0, 0, 64'h0001_0203_0405_0607);
    drive_word(0, 0, 0, 64'h1011_1213_1415_1617);
    drive_word(0, 0, 0, 64'h2021_2223_2425_2627);
    check("valid_before_last", bus.out_valid, 0);
    drive_word(0, 1, 0, 64'h3031_3233_3435_3637);
    @(negedge clk);
    check("latency_valid", bus.out_valid, 1);
    drain();
    check("t1_sop",   last_beat.sop,  4'b1000);
    check("t1_eop",   last_beat.eop,  4'b0001);
    check("t1_dval",  last_beat.dval, 4'b1111);
    check("t1_pkt",   last_beat.pkt,  16'h1111);
    check("t1_zero0", last_beat.zero[11:0], 0);

    // One-word packet with mod=3, then a three-word packet
    drive_word(1, 1, 3, 64'hA0A1_A2A3_A4A5_A6A7);
    drive_word(1, 0, 0, 64'hB0B1_B2B3_B4B5_B6B7);
    drive_word(0, 0, 0, 64'hC0C1_C2C3_C4C5_C6C7);
    drive_word(0, 1, 0, 64'hD0D1_D2D3_D4D5_D6D7);
    drain();
    check("t2_zero3", last_beat.zero[47:36], 12'd29);
    check("t2_pkt",   last_beat.pkt, 16'h1222);
    check("t2_eop",   last_beat.eop, 4'b1001);

    // Idle flush of a partial beat with the packet still open
    drive_word(1, 0, 0, {$urandom, $urandom});
    drive_word(0, 0, 0, {$urandom, $urandom});
    model_flush();
    early = 0;
    repeat (16) begin
      @(negedge clk);
      if (bus.out_valid) early = 1;
    end
    check("flush_not_early", early, 0);
    drain();
    check("flush_dval", last_beat.dval, 4'b1100);
    check("flush_low_data", last_beat.data[127:0], 0);
    check("flush_low_pkt", last_beat.pkt[7:0], 0);
    check("flush_err_proto", err_a, 0);
    drive_word(0, 0, 0, {$urandom, $urandom});
    drive_word(0, 1, 5, {$urandom, $urandom});
    drive_word(1, 1, 0, {$urandom, $urandom});
    drive_word(1, 1, 2, {$urandom, $urandom});
    drain();
    check("continue_err_proto", err_a, 0);

    // Downstream stall while streaming 12 words
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    stall_seen = 0;
    fork
      begin
        for (int p = 0; p < 3; p++)
          for (int i = 0; i < 4; i++)
            drive_word(i == 0, i == 3, 3'(p), {$urandom, $urandom});
      end
      begin
        repeat (10) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();
    check("stall_in_ready_low", stall_seen, 1);

    // Protocol error, stickiness, and reset mid-beat
    drive_word(1, 0, 0, {$urandom, $urandom});
    drive_word(1, 0, 0, {$urandom, $urandom});
    check("err_proto_set", err_a, 1);
    drive_word(0, 0, 0, {$urandom, $urandom});
    check("err_proto_sticky", err_a, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready",  bus.in_ready, 0);
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_seg_data",  bus.out_seg_data, 0);
    check("mid_rst_seg_dval",  bus.out_seg_dval, 0);
    check("mid_rst_err",       {err_a, ovf_a}, 0);
    rst = 1'b0;
    model_clear();
    drive_word(1, 0, 0, {$urandom, $urandom});
    drive_word(0, 0, 0, {$urandom, $urandom});
    drive_word(0, 0, 0, {$urandom, $urandom});
    drive_word(0, 1, 6, {$urandom, $urandom});
    drain();
    check("post_rst_sop", last_beat.sop, 4'b1000);
    check("post_rst_err", err_a, 0);

    // Packet ordinal saturation on the 16-segment build, flush disabled
    for (int k = 0; k < 16; k++) begin
      drive_b(64'(k + 1));
      if (k == 5) check("b_ovf_clear_at_6", ovf_b, 0);
      if (k == 8) begin
        check("b_ovf_set_at_9", ovf_b, 1);
        early = 0;
        repeat (30) begin
          @(negedge clk);
          if (busb.out_valid) early = 1;
        end
        check("b_no_flush", early, 0);
      end
    end
    exp_pkt_b  = '0;
    exp_zero_b = '0;
    for (int s = 0; s < 16; s++) begin
      exp_pkt_b[s*3 +: 3]   = 3'(((15 - s) + 1 > 7) ? 7 : (15 - s) + 1);
      exp_zero_b[s*12 +: 12] = 12'(s * 8);
    end
    w = 0;
    @(negedge clk);
    while (!busb.out_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("b_valid",   busb.out_valid, 1);
    check("b_pkt",     busb.out_seg_pkt_num, exp_pkt_b);
    check("b_zero",    busb.out_seg_zero_num, exp_zero_b);
    check("b_eop",     busb.out_seg_eop, 16'hFFFF);
    check("b_dval",    busb.out_seg_dval, 16'hFFFF);
    check("b_data0",   busb.out_seg_data[63:0], wr_data(64'd16));
    check("b_ovf_sticky", ovf_b, 1);
    check("b_err_proto", err_b, 0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
